// File: rtl/hd_transmissor_programa_pkg.sv
// Shared definitions for the HD program loader: FSM encoding, interface codes
// and the block size that the instruction memory also uses for cursor advance.
package hd_transmissor_programa_pkg;

  localparam int TAM_BLOCO = 200;
  localparam int CONT_W    = $clog2(TAM_BLOCO + 1);

  localparam logic [1:0] SALVA_ATIVO = 2'b01;
  localparam logic [1:0] FIM_ATIVO   = 2'b01;
  localparam logic [1:0] INATIVO     = 2'b00;

  typedef enum logic [2:0] {
    OCIOSO,
    LER,
    TRANSFERIR,
    FIM,
    CONCLUIDO
  } estado_t;

endpackage

// File: rtl/hd_transmissor_programa_gerador_endereco.sv
// Address generator for the HD loader: block base computation, read counter
// and the next address to issue.
module hd_gerador_endereco
  import hd_transmissor_programa_pkg::*;
#(
  parameter int LARGURA_END_HD = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      carregar,
  input  logic                      avancar,
  input  logic [31:0]               numeroPrograma,
  input  logic [CONT_W-1:0]         tamanho,
  output logic [LARGURA_END_HD-1:0] base,
  output logic [LARGURA_END_HD-1:0] proximo,
  output logic                      ha_proximo,
  output logic [CONT_W-1:0]         total
);

  logic [LARGURA_END_HD-1:0] base_r;
  logic [CONT_W-1:0]         cont;

  // The product is reduced modulo 2^LARGURA_END_HD; addresses wrap silently.
  assign base = LARGURA_END_HD'(numeroPrograma * 32'(TAM_BLOCO));

  always_ff @(posedge clock) begin
    if (reset) begin
      base_r <= '0;
      cont   <= '0;
      total  <= '0;
    end else if (carregar) begin
      base_r <= base;
      total  <= tamanho;
      cont   <= CONT_W'(1);
    end else if (avancar) begin
      cont <= cont + CONT_W'(1);
    end
  end

  // cont counts addresses already issued, so it is also the next offset.
  assign proximo    = base_r + LARGURA_END_HD'(cont);
  assign ha_proximo = (cont < total);

endmodule

// File: rtl/hd_transmissor_programa.sv
// HD-side loader: streams one program block into the instruction memory at one
// word per cycle, then signals end-of-read so the receiver moves to the next block.
module hd_transmissor_programa
  import hd_transmissor_programa_pkg::*;
#(
  parameter int LARGURA_END_HD = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciarLeitura,
  input  logic [31:0]               numeroPrograma,
  input  logic [31:0]               tamanhoPrograma,
  output logic [LARGURA_END_HD-1:0] hd_endereco,
  output logic                      hd_leitura,
  input  logic [31:0]               hd_dado,
  output logic [31:0]               entradaDeInstrucao,
  output logic [1:0]                controleSalvaInstrucao,
  output logic [1:0]                ControleFimDeLeitura,
  output logic                      leituraOcupada,
  output logic                      leituraConcluida,
  output logic                      erroTamanho
);

  estado_t estado, estado_n;

  logic [LARGURA_END_HD-1:0] end_n;
  logic                      leit_n;
  logic [31:0]               instr_n;
  logic [1:0]                salva_n, fim_n;
  logic                      ocup_n, concl_n, erro_n;
  logic [CONT_W-1:0]         palavras, palavras_n;

  logic                      carregar, avancar, ha_proximo;
  logic [LARGURA_END_HD-1:0] base, proximo;
  logic [CONT_W-1:0]         total;

  hd_gerador_endereco #(
    .LARGURA_END_HD(LARGURA_END_HD)
  ) u_gerador (
    .clock         (clock),
    .reset         (reset),
    .carregar      (carregar),
    .avancar       (avancar),
    .numeroPrograma(numeroPrograma),
    .tamanho       (CONT_W'(tamanhoPrograma)),
    .base          (base),
    .proximo       (proximo),
    .ha_proximo    (ha_proximo),
    .total         (total)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado                 <= OCIOSO;
      hd_endereco            <= '0;
      hd_leitura             <= 1'b0;
      entradaDeInstrucao     <= '0;
      controleSalvaInstrucao <= INATIVO;
      ControleFimDeLeitura   <= INATIVO;
      leituraOcupada         <= 1'b0;
      leituraConcluida       <= 1'b0;
      erroTamanho            <= 1'b0;
      palavras               <= '0;
    end else begin
      estado                 <= estado_n;
      hd_endereco            <= end_n;
      hd_leitura             <= leit_n;
      entradaDeInstrucao     <= instr_n;
      controleSalvaInstrucao <= salva_n;
      ControleFimDeLeitura   <= fim_n;
      leituraOcupada         <= ocup_n;
      leituraConcluida       <= concl_n;
      erroTamanho            <= erro_n;
      palavras               <= palavras_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    end_n      = hd_endereco;
    leit_n     = hd_leitura;
    instr_n    = entradaDeInstrucao;
    salva_n    = INATIVO;
    fim_n      = INATIVO;
    ocup_n     = leituraOcupada;
    concl_n    = 1'b0;
    erro_n     = 1'b0;
    palavras_n = palavras;
    carregar   = 1'b0;
    avancar    = 1'b0;

    case (estado)
      OCIOSO: begin
        if (iniciarLeitura) begin
          if (tamanhoPrograma > 32'(TAM_BLOCO)) begin
            erro_n = 1'b1;
          end else if (tamanhoPrograma == 32'd0) begin
            carregar = 1'b1;
            ocup_n   = 1'b1;
            estado_n = FIM;
          end else begin
            carregar   = 1'b1;
            end_n      = base;
            leit_n     = 1'b1;
            ocup_n     = 1'b1;
            palavras_n = '0;
            estado_n   = LER;
          end
        end
      end
      LER: begin
        if (ha_proximo) begin
          end_n   = proximo;
          avancar = 1'b1;
        end else begin
          leit_n = 1'b0;
        end
        estado_n = TRANSFERIR;
      end
      TRANSFERIR: begin
        // Read issue runs one word ahead of the data being forwarded.
        instr_n    = hd_dado;
        salva_n    = SALVA_ATIVO;
        palavras_n = palavras + CONT_W'(1);
        if (ha_proximo) begin
          end_n   = proximo;
          avancar = 1'b1;
        end else begin
          leit_n = 1'b0;
        end
        if (palavras == total - CONT_W'(1)) begin
          estado_n = FIM;
        end
      end
      FIM: begin
        fim_n    = FIM_ATIVO;
        estado_n = CONCLUIDO;
      end
      CONCLUIDO: begin
        concl_n  = 1'b1;
        ocup_n   = 1'b0;
        estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase
  end

endmodule

// File: tb/tb_hd_transmissor_programa.sv
// Directed bench for the HD program loader with HD and instruction-memory models.
module tb_hd_transmissor_programa;
  import hd_transmissor_programa_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciarLeitura = 1'b0;
  logic [31:0] numeroPrograma = '0;
  logic [31:0] tamanhoPrograma = '0;
  logic [15:0] hd_endereco;
  logic        hd_leitura;
  logic [31:0] hd_dado = '0;
  logic [31:0] entradaDeInstrucao;
  logic [1:0]  controleSalvaInstrucao;
  logic [1:0]  ControleFimDeLeitura;
  logic        leituraOcupada;
  logic        leituraConcluida;
  logic        erroTamanho;

  int vectors = 0;
  int miscompares = 0;

  hd_transmissor_programa #(.LARGURA_END_HD(16)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .iniciarLeitura        (iniciarLeitura),
    .numeroPrograma        (numeroPrograma),
    .tamanhoPrograma       (tamanhoPrograma),
    .hd_endereco           (hd_endereco),
    .hd_leitura            (hd_leitura),
    .hd_dado               (hd_dado),
    .entradaDeInstrucao    (entradaDeInstrucao),
    .controleSalvaInstrucao(controleSalvaInstrucao),
    .ControleFimDeLeitura  (ControleFimDeLeitura),
    .leituraOcupada        (leituraOcupada),
    .leituraConcluida      (leituraConcluida),
    .erroTamanho           (erroTamanho)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] hd_val(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  // HD model: one-cycle read latency.
  always @(posedge clock) hd_dado <= hd_leitura ? hd_val(hd_endereco) : 32'hDEAD_DEAD;

  // Instruction-memory model: writes on negedge, end-of-read advances a block.
  logic [31:0] imem [0:511];
  int          cursor = 0;
  int          overlap = 0;
  logic        imem_clear = 1'b0;
  always @(negedge clock) begin
    if (imem_clear) cursor = 0;
    else begin
      if (controleSalvaInstrucao == 2'b01 && ControleFimDeLeitura == 2'b01) overlap++;
      if (controleSalvaInstrucao == 2'b01) begin
        if (cursor < 512) imem[cursor] = entradaDeInstrucao;
        cursor++;
      end
      if (ControleFimDeLeitura == 2'b01) cursor += TAM_BLOCO;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input int prog, input int n);
    numeroPrograma  = prog;
    tamanhoPrograma = n;
    iniciarLeitura  = 1'b1;
    tick();
    iniciarLeitura  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({hd_endereco, hd_leitura, entradaDeInstrucao, controleSalvaInstrucao, ControleFimDeLeitura,
         leituraOcupada, leituraConcluida, erroTamanho} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got addr=%0d leit=%b instr=%h salva=%b fim=%b ocup=%b concl=%b erro=%b, required all zero",
               hd_endereco, hd_leitura, entradaDeInstrucao, controleSalvaInstrucao, ControleFimDeLeitura,
               leituraOcupada, leituraConcluida, erroTamanho);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp_addr [0:2];
    exp_addr[0] = 16'd400; exp_addr[1] = 16'd401; exp_addr[2] = 16'd402;
    start(2, 3);
    for (int e = 0; e < 3; e++) begin
      vectors++;
      if (hd_endereco !== exp_addr[e] || hd_leitura !== 1'b1 || leituraOcupada !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_addr E%0d: got addr=%0d leit=%b ocup=%b, required addr=%0d leit=1 ocup=1",
                 e, hd_endereco, hd_leitura, leituraOcupada, exp_addr[e]);
      end
      if (e >= 2) begin
        vectors++;
        if (controleSalvaInstrucao !== 2'b01 || entradaDeInstrucao !== hd_val(16'd400)) begin
          miscompares++;
          $display("FAIL basic_word0: got salva=%b instr=%h, required 01 %h",
                   controleSalvaInstrucao, entradaDeInstrucao, hd_val(16'd400));
        end
      end
      if (e < 2) tick();
    end
    for (int w = 1; w < 3; w++) begin
      tick();
      vectors++;
      if (controleSalvaInstrucao !== 2'b01 || entradaDeInstrucao !== hd_val(16'(400 + w))) begin
        miscompares++;
        $display("FAIL basic_word%0d: got salva=%b instr=%h, required 01 %h",
                 w, controleSalvaInstrucao, entradaDeInstrucao, hd_val(16'(400 + w)));
      end
    end
    vectors++;
    if (hd_leitura !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_leit_drop: got %b, required 0", hd_leitura);
    end
    tick();
    vectors++;
    if (ControleFimDeLeitura !== 2'b01 || controleSalvaInstrucao !== 2'b00 || leituraConcluida !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_fim E5: got fim=%b salva=%b concl=%b, required 01 00 0",
               ControleFimDeLeitura, controleSalvaInstrucao, leituraConcluida);
    end
    tick();
    vectors++;
    if (ControleFimDeLeitura !== 2'b00 || leituraConcluida !== 1'b1 || leituraOcupada !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_concl E6: got fim=%b concl=%b ocup=%b, required 00 1 0",
               ControleFimDeLeitura, leituraConcluida, leituraOcupada);
    end
    tick();
    vectors++;
    if (leituraConcluida !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_concl_pulse: got %b, required 0", leituraConcluida);
    end
  endtask

  task automatic test_zero();
    int salvas = 0;
    start(5, 0);
    vectors++;
    if (hd_leitura !== 1'b0 || controleSalvaInstrucao !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_E0: got leit=%b salva=%b, required 0 00", hd_leitura, controleSalvaInstrucao);
    end
    tick();
    vectors++;
    if (ControleFimDeLeitura !== 2'b01 || controleSalvaInstrucao !== 2'b00) begin
      miscompares++;
      $display("FAIL zero_fim: got fim=%b salva=%b, required 01 00", ControleFimDeLeitura, controleSalvaInstrucao);
    end
    tick();
    vectors++;
    if (leituraConcluida !== 1'b1 || ControleFimDeLeitura !== 2'b00 || leituraOcupada !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_concl: got concl=%b fim=%b ocup=%b, required 1 00 0",
               leituraConcluida, ControleFimDeLeitura, leituraOcupada);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (controleSalvaInstrucao == 2'b01) salvas++;
    end
    vectors++;
    if (salvas !== 0) begin
      miscompares++;
      $display("FAIL zero_no_salva: got %0d salva cycles, required 0", salvas);
    end
  endtask

  task automatic test_erro();
    int leits = 0;
    int erros = 0;
    int ocups = 0;
    start(1, 201);
    vectors++;
    if (erroTamanho !== 1'b1) begin
      miscompares++;
      $display("FAIL erro_pulse: got %b, required 1", erroTamanho);
    end
    erros = 1;
    for (int c = 0; c < 6; c++) begin
      if (hd_leitura) leits++;
      if (leituraOcupada) ocups++;
      tick();
      if (erroTamanho) erros++;
    end
    vectors++;
    if (erros !== 1 || leits !== 0 || ocups !== 0) begin
      miscompares++;
      $display("FAIL erro_quiet: got erro_cycles=%0d leit_cycles=%0d ocup_cycles=%0d, required 1 0 0",
               erros, leits, ocups);
    end
    start(1, 200);
    vectors++;
    if (erroTamanho !== 1'b0 || hd_leitura !== 1'b1 || hd_endereco !== 16'd200) begin
      miscompares++;
      $display("FAIL erro_limit200: got erro=%b leit=%b addr=%0d, required 0 1 200",
               erroTamanho, hd_leitura, hd_endereco);
    end
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic test_ignore();
    int salvas = 0, fims = 0, concls = 0, erros = 0, concl_at = -1;
    start(3, 5);
    for (int c = 1; c < 14; c++) begin
      if (c == 3) begin
        numeroPrograma = 7; tamanhoPrograma = 250; iniciarLeitura = 1'b1;
      end
      tick();
      iniciarLeitura = 1'b0;
      if (controleSalvaInstrucao == 2'b01) salvas++;
      if (ControleFimDeLeitura == 2'b01) fims++;
      if (erroTamanho) erros++;
      if (leituraConcluida) begin concls++; concl_at = c; end
    end
    vectors++;
    if (salvas !== 5 || fims !== 1 || concls !== 1 || erros !== 0) begin
      miscompares++;
      $display("FAIL ignore_counts: got salva=%0d fim=%0d concl=%0d erro=%0d, required 5 1 1 0",
               salvas, fims, concls, erros);
    end
    vectors++;
    if (concl_at !== 8) begin
      miscompares++;
      $display("FAIL ignore_latency: got done at E%0d, required E8", concl_at);
    end
  endtask

  task automatic test_reset_mid();
    int fims = 0;
    start(4, 5);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (controleSalvaInstrucao !== 2'b00 || ControleFimDeLeitura !== 2'b00 || leituraOcupada !== 1'b0 ||
        hd_leitura !== 1'b0 || hd_endereco !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got salva=%b fim=%b ocup=%b leit=%b addr=%0d, required 00 00 0 0 0",
               controleSalvaInstrucao, ControleFimDeLeitura, leituraOcupada, hd_leitura, hd_endereco);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ControleFimDeLeitura == 2'b01) fims++;
    end
    vectors++;
    if (fims !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_nofim: got %0d fim pulses, required 0", fims);
    end
  endtask

  task automatic wait_done(input string nome);
    int c = 0;
    while (!leituraConcluida && c < 30) begin tick(); c++; end
    vectors++;
    if (!leituraConcluida) begin
      miscompares++;
      $display("FAIL %s_timeout: got no done pulse in 30 cycles, required one", nome);
    end
  endtask

  task automatic test_back_to_back();
    imem_clear = 1'b1; tick(); imem_clear = 1'b0;
    overlap = 0;
    start(0, 4);
    wait_done("prog0");
    start(1, 4);
    wait_done("prog1");
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (imem[i] !== hd_val(16'(i))) begin
        miscompares++;
        $display("FAIL b2b_prog0[%0d]: got %h, required %h", i, imem[i], hd_val(16'(i)));
      end
      vectors++;
      if (imem[204 + i] !== hd_val(16'(200 + i))) begin
        miscompares++;
        $display("FAIL b2b_prog1[%0d]: got %h, required %h", 204 + i, imem[204 + i], hd_val(16'(200 + i)));
      end
    end
    vectors++;
    if (cursor !== 408 || overlap !== 0) begin
      miscompares++;
      $display("FAIL b2b_cursor: got cursor=%0d overlap=%0d, required 408 0", cursor, overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_erro();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
